// File: rtl/display_arbiter_pkg.sv
// Shared codes and helpers for the 4-digit display arbiter.
// Game states, display sources and the blank/idle drive patterns.
package ddr_display_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_PAUSE    = 2'd2,
        ST_GAMEOVER = 2'd3
    } gameState_t;

    typedef enum logic [1:0] {
        SRC_FIELD = 2'd0,
        SRC_SCORE = 2'd1,
        SRC_COMBO = 2'd2,
        SRC_LIVES = 2'd3
    } srcSel_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    function automatic logic [6:0] digitOf(
        input logic [27:0] segs,
        input logic [1:0]  idx
    );
        return segs[int'(idx)*7 +: 7];
    endfunction

    function automatic logic [3:0] anodeOf(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Producer-side bundle for the display arbiter: game inputs,
// segment sources and the registered display drive.
interface display_arbiter_if;

    logic [1:0]  state;
    logic        combo_evt;
    logic        life_evt;
    logic        blank;
    logic [27:0] field_segs;
    logic [27:0] score_segs;
    logic [27:0] combo_segs;
    logic [27:0] lives_segs;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  src_sel;
    logic        frame_start;

    modport master (
        output state, combo_evt, life_evt, blank,
        output field_segs, score_segs, combo_segs, lives_segs,
        input  seg, an, src_sel, frame_start
    );

    modport slave (
        input  state, combo_evt, life_evt, blank,
        input  field_segs, score_segs, combo_segs, lives_segs,
        output seg, an, src_sel, frame_start
    );

endinterface

// File: rtl/display_arbiter_seg_scan_counter.sv
// Digit scan timebase: dwell counter, digit index and frame pulse.
// frameEdge flags the cycle whose clock edge wraps idx 3->0.
module seg_scan_counter #(
    parameter int DIGIT_TICKS = 50000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] idx,
    output logic       frameStart,
    output logic       frameEdge
);

    localparam int CW = $clog2(DIGIT_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGIT_TICKS - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick      = (cnt == LAST);
    assign frameEdge = tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= frameEdge;
            if (tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Single owner of the 7-segment display: frame-aligned source select,
// banner hold timers, GAMEOVER alternation and registered seg/an drive.
module display_arbiter
    import ddr_display_pkg::*;
#(
    parameter int DIGIT_TICKS  = 50000,
    parameter int COMBO_FRAMES = 250,
    parameter int LIFE_FRAMES  = 500,
    parameter int ALT_FRAMES   = 500
) (
    input logic              clk,
    input logic              reset,
    display_arbiter_if.slave bus
);

    localparam int CW = $clog2(COMBO_FRAMES + 1);
    localparam int LW = $clog2(LIFE_FRAMES + 1);
    localparam int AW = $clog2(ALT_FRAMES + 1);

    localparam logic [CW-1:0] COMBO_LOAD = CW'(COMBO_FRAMES);
    localparam logic [LW-1:0] LIFE_LOAD  = LW'(LIFE_FRAMES);
    localparam logic [AW-1:0] ALT_LAST   = AW'(ALT_FRAMES - 1);

    logic [1:0] idx;
    logic       frameStart;
    logic       frameEdge;

    seg_scan_counter #(
        .DIGIT_TICKS(DIGIT_TICKS)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .idx       (idx),
        .frameStart(frameStart),
        .frameEdge (frameEdge)
    );

    gameState_t st;
    gameState_t prevState;
    logic       entering;

    assign st       = gameState_t'(bus.state);
    assign entering = (st == ST_GAMEOVER) && (prevState != ST_GAMEOVER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prevState <= ST_INIT;
        else        prevState <= st;
    end

    logic [CW-1:0] comboCnt;
    logic [LW-1:0] lifeCnt;

    // Banners only load and age while playing; PAUSE freezes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            comboCnt <= '0;
            lifeCnt  <= '0;
        end else if (entering) begin
            comboCnt <= '0;
            lifeCnt  <= '0;
        end else if (st == ST_PLAY) begin
            if (bus.combo_evt)
                comboCnt <= COMBO_LOAD;
            else if (frameEdge && comboCnt != '0)
                comboCnt <= comboCnt - CW'(1);
            if (bus.life_evt)
                lifeCnt <= LIFE_LOAD;
            else if (frameEdge && lifeCnt != '0)
                lifeCnt <= lifeCnt - LW'(1);
        end
    end

    logic [AW-1:0] altCnt;
    logic          altPhase;
    logic [AW-1:0] altBase;
    logic          phaseBase;
    logic          altWrap;

    // On entry the alternation restarts from SCORE even mid-cycle.
    assign altBase   = entering ? '0 : altCnt;
    assign phaseBase = entering ? 1'b0 : altPhase;
    assign altWrap   = (altBase == ALT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            altCnt   <= '0;
            altPhase <= 1'b0;
        end else if (st == ST_GAMEOVER) begin
            if (frameEdge) begin
                altCnt   <= altWrap ? '0 : altBase + AW'(1);
                altPhase <= phaseBase ^ altWrap;
            end else begin
                altCnt   <= altBase;
                altPhase <= phaseBase;
            end
        end
    end

    srcSel_t srcSel;
    srcSel_t srcNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) srcSel <= SRC_SCORE;
        else        srcSel <= srcNext;
    end

    always_comb begin
        srcNext = srcSel;
        if (frameEdge) begin
            unique case (st)
                ST_INIT, ST_PAUSE: srcNext = SRC_SCORE;
                ST_PLAY: begin
                    if (lifeCnt != '0)
                        srcNext = SRC_LIVES;
                    else if (comboCnt != '0)
                        srcNext = SRC_COMBO;
                    else
                        srcNext = SRC_FIELD;
                end
                ST_GAMEOVER:
                    srcNext = phaseBase ? SRC_LIVES : SRC_SCORE;
                default: srcNext = SRC_SCORE;
            endcase
        end
    end

    logic [27:0] srcSegs;

    always_comb begin
        srcSegs = bus.field_segs;
        unique case (srcSel)
            SRC_FIELD: srcSegs = bus.field_segs;
            SRC_SCORE: srcSegs = bus.score_segs;
            SRC_COMBO: srcSegs = bus.combo_segs;
            SRC_LIVES: srcSegs = bus.lives_segs;
            default:   srcSegs = bus.field_segs;
        endcase
    end

    logic [6:0] segReg;
    logic [3:0] anReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            segReg <= SEG_BLANK;
            anReg  <= AN_OFF;
        end else if (bus.blank) begin
            segReg <= SEG_BLANK;
            anReg  <= AN_OFF;
        end else begin
            segReg <= digitOf(srcSegs, idx);
            anReg  <= anodeOf(idx);
        end
    end

    assign bus.seg         = segReg;
    assign bus.an          = anReg;
    assign bus.src_sel     = srcSel;
    assign bus.frame_start = frameStart;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with short scan and banner timings.
module tb_display_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    display_arbiter_if bus ();

    display_arbiter #(
        .DIGIT_TICKS (4),
        .COMBO_FRAMES(2),
        .LIFE_FRAMES (3),
        .ALT_FRAMES  (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic waitFrame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_start && n < 40);
        if (!bus.frame_start) begin
            checks++;
            errors++;
            $display("FAIL %s: no frame_start in %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset;
        step();
        checks++;
        if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.src_sel !== 2'd1 ||
            bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: seg=%h an=%b src=%0d fs=%b want 7f 1111 1 0",
                     bus.seg, bus.an, bus.src_sel, bus.frame_start);
        end
        reset = 1'b1;
        repeat (6) step();
        checks++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'h21) begin
            errors++;
            $display("FAIL pre_abort: an=%b seg=%h want 1101 21", bus.an, bus.seg);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.seg !== 7'h7F || bus.an !== 4'hF || bus.src_sel !== 2'd1) begin
            errors++;
            $display("FAIL async_abort: seg=%h an=%b src=%0d want 7f 1111 1",
                     bus.seg, bus.an, bus.src_sel);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h20 || bus.src_sel !== 2'd1) begin
            errors++;
            $display("FAIL release_1: an=%b seg=%h src=%0d want 1110 20 1",
                     bus.an, bus.seg, bus.src_sel);
        end
        repeat (3) step();
        checks++;
        if (bus.an !== 4'b1110) begin
            errors++;
            $display("FAIL release_4: an=%b want 1110", bus.an);
        end
        step();
        checks++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'h21) begin
            errors++;
            $display("FAIL release_5: an=%b seg=%h want 1101 21", bus.an, bus.seg);
        end
    endtask

    task automatic test_scan;
        logic [3:0] ea;
        logic [6:0] es;
        bus.state = 2'd1;
        waitFrame("scan_sync");
        checks++;
        if (bus.src_sel !== 2'd0) begin
            errors++;
            $display("FAIL play_field: src=%0d want 0", bus.src_sel);
        end
        for (int k = 0; k < 4; k++) begin
            ea = ~(4'b0001 << k);
            es = 7'h10 + 7'(k);
            for (int t = 0; t < 4; t++) begin
                step();
                checks++;
                if (bus.an !== ea || bus.seg !== es) begin
                    errors++;
                    $display("FAIL scan d%0d t%0d: an=%b seg=%h want %b %h",
                             k, t, bus.an, bus.seg, ea, es);
                end
            end
        end
        checks++;
        if (bus.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_period: fs=%b want 1 after 16 clk", bus.frame_start);
        end
    endtask

    task automatic test_combo;
        logic [1:0] exp [3] = '{2'd2, 2'd2, 2'd0};
        bus.combo_evt = 1'b1;
        step();
        bus.combo_evt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waitFrame("combo");
            checks++;
            if (bus.src_sel !== exp[i]) begin
                errors++;
                $display("FAIL combo f%0d: src=%0d want %0d", i, bus.src_sel, exp[i]);
            end
        end
    endtask

    task automatic test_both;
        logic [1:0] exp [4] = '{2'd3, 2'd3, 2'd3, 2'd0};
        bus.combo_evt = 1'b1;
        bus.life_evt  = 1'b1;
        step();
        bus.combo_evt = 1'b0;
        bus.life_evt  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waitFrame("both");
            checks++;
            if (bus.src_sel !== exp[i]) begin
                errors++;
                $display("FAIL both f%0d: src=%0d want %0d", i, bus.src_sel, exp[i]);
            end
        end
    endtask

    task automatic test_pause;
        logic [1:0] exp [6] = '{2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0};
        bus.life_evt = 1'b1;
        step();
        bus.life_evt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            waitFrame("pause");
            checks++;
            if (bus.src_sel !== exp[i]) begin
                errors++;
                $display("FAIL pause f%0d: src=%0d want %0d", i, bus.src_sel, exp[i]);
            end
            if (i == 0) begin
                step();
                bus.state = 2'd2;
            end
            if (i == 2) bus.state = 2'd1;
        end
    endtask

    task automatic test_blank;
        bus.blank = 1'b1;
        step();
        checks++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
            errors++;
            $display("FAIL blank_on: an=%b seg=%h want 1111 7f", bus.an, bus.seg);
        end
        waitFrame("blank_scan");
        bus.blank = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h10) begin
            errors++;
            $display("FAIL blank_off: an=%b seg=%h want 1110 10", bus.an, bus.seg);
        end
    endtask

    task automatic test_gameover;
        logic [1:0] exp [6] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
        bus.life_evt = 1'b1;
        step();
        bus.life_evt = 1'b0;
        bus.state = 2'd3;
        step();
        step();
        checks++;
        if (bus.src_sel !== 2'd0) begin
            errors++;
            $display("FAIL go_midframe: src=%0d want 0", bus.src_sel);
        end
        for (int i = 0; i < 6; i++) begin
            waitFrame("gameover");
            checks++;
            if (bus.src_sel !== exp[i]) begin
                errors++;
                $display("FAIL gameover f%0d: src=%0d want %0d", i, bus.src_sel, exp[i]);
            end
            if (i == 2) begin
                step();
                checks++;
                if (bus.seg !== 7'h40) begin
                    errors++;
                    $display("FAIL lives_seg: seg=%h want 40", bus.seg);
                end
            end
        end
        bus.combo_evt = 1'b1;
        step();
        bus.combo_evt = 1'b0;
        bus.state = 2'd1;
        waitFrame("go_exit");
        checks++;
        if (bus.src_sel !== 2'd0) begin
            errors++;
            $display("FAIL go_cleared: src=%0d want 0", bus.src_sel);
        end
    endtask

    initial begin
        bus.state      = 2'd0;
        bus.combo_evt  = 1'b0;
        bus.life_evt   = 1'b0;
        bus.blank      = 1'b0;
        bus.field_segs = {7'h13, 7'h12, 7'h11, 7'h10};
        bus.score_segs = {7'h23, 7'h22, 7'h21, 7'h20};
        bus.combo_segs = {7'h33, 7'h32, 7'h31, 7'h30};
        bus.lives_segs = {7'h43, 7'h42, 7'h41, 7'h40};
        test_reset();
        test_scan();
        test_combo();
        test_both();
        test_pause();
        test_blank();
        test_gameover();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
